// File: rtl/fp_normalize_round.sv
// Post-addition normalise/round stage of the single-precision FP adder.
// Shifts the extended magnitude one bit per cycle, rounds to nearest-even, packs an IEEE-754 result.
module fp_normalize_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int MAG_W  = FRAC_W + 5
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic [MAG_W-1:0]        mag_in,
    output logic                    busy,
    output logic                    done,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    overflow,
    output logic                    underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_sign;
    logic [EXP_W-1:0]   r_exp;
    logic [MAG_W-1:0]   r_mag;

    logic [MAG_W-1:0]   w_mag_rshift;
    logic [EXP_W-1:0]   w_exp_inc;
    logic               w_round_up;
    logic [MAG_W-4:0]   w_mag_hi;
    logic [MAG_W-1:0]   w_mag_rnd;

    // Right shift folds the dropped R bit into sticky so no information is lost for rounding.
    assign w_mag_rshift = {1'b0, r_mag[MAG_W-1:2], r_mag[1] | r_mag[0]};
    assign w_exp_inc    = r_exp + EXP_W'(1);
    assign w_round_up   = r_mag[2] & (r_mag[1] | r_mag[0] | r_mag[3]);
    assign w_mag_hi     = r_mag[MAG_W-1:3] + {{(MAG_W-4){1'b0}}, w_round_up};
    assign w_mag_rnd    = {w_mag_hi, 3'b000};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mag     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign    <= sign_in;
                        r_exp     <= exp_in;
                        r_mag     <= mag_in;
                        busy      <= 1'b1;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        r_state   <= NORM;
                    end
                end
                NORM: begin
                    if (r_mag == '0) begin
                        result  <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_mag[MAG_W-1]) begin
                        r_mag <= w_mag_rshift;
                        r_exp <= w_exp_inc;
                        if (w_exp_inc == {EXP_W{1'b1}}) begin
                            result   <= {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                            overflow <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end else if (!r_mag[MAG_W-2]) begin
                        if (r_exp <= EXP_W'(1)) begin
                            result    <= {r_sign, {(EXP_W+FRAC_W){1'b0}}};
                            underflow <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_mag <= {r_mag[MAG_W-2:0], 1'b0};
                            r_exp <= r_exp - EXP_W'(1);
                        end
                    end else begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    if (w_mag_rnd[MAG_W-1]) begin
                        // Rounding carried out of the hidden bit; renormalise through NORM.
                        r_mag   <= w_mag_rnd;
                        r_state <= NORM;
                    end else begin
                        result  <= {r_sign, r_exp, w_mag_rnd[MAG_W-3:3]};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench for fp_normalize_round: directed cases from the plan plus random
// operations compared against an arithmetic reference model.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [27:0] mag_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_normalize_round dut (
        .clock     (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mag_in    (mag_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, expv);
        end
    endtask

    // Value-level model: the magnitude is an integer scaled by 8 (three round bits), moved with
    // multiply/divide; lat counts working cycles between the start edge and the done edge.
    task automatic ref_model(input bit s, input int e_in, input longint m_in,
                             output logic [31:0] res, output bit ov, output bit un, output int lat);
        longint m;
        int     e;
        longint low;
        bit     lsb, up;
        m = m_in; e = e_in; lat = 0; ov = 0; un = 0; res = 0;
        for (int it = 0; it < 200; it++) begin
            lat++;
            if (m == 0) begin
                res = 32'h0; return;
            end else if (m >= (64'd1 << 27)) begin
                m = (m / 4) * 2 + ((m % 4) != 0 ? 1 : 0);
                e = (e + 1) % 256;
                if (e == 255) begin
                    res = {s, 8'hFF, 23'h0}; ov = 1; return;
                end
            end else if (m < (64'd1 << 26)) begin
                if (e <= 1) begin
                    res = {s, 31'h0}; un = 1; return;
                end
                m = m * 2;
                e = e - 1;
            end else begin
                lat++;
                low = m % 8;
                lsb = ((m / 8) % 2) != 0;
                up  = (low > 4) || (low == 4 && lsb);
                m   = (m / 8 + (up ? 1 : 0)) * 8;
                if (m < (64'd1 << 27)) begin
                    res = {s, e[7:0], 23'((m / 8) % (64'd1 << 23))};
                    return;
                end
            end
        end
    endtask

    task automatic run_op(input bit s, input logic [7:0] e, input logic [27:0] m,
                          input bit align, input bit poke, input bit tail, input string tag);
        logic [31:0] eres;
        bit          eov, eun;
        int          elat, cyc;
        ref_model(s, int'(e), longint'(m), eres, eov, eun, elat);
        if (align) @(negedge clk);
        sign_in = s; exp_in = e; mag_in = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk(tag, "busy_after_start", 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (poke && cyc == 0) begin
                start = 1'b1; sign_in = ~s; exp_in = 8'd100; mag_in = 28'h4000000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        $display("op %s: sign=%0d exp=%0d mag=%h -> result=%h ovf=%0d unf=%0d after %0d cycles",
                 tag, s, e, m, result, overflow, underflow, cyc);
        chk(tag, "latency", 32'(cyc), 32'(elat));
        chk(tag, "result", result, eres);
        chk(tag, "overflow", 32'(overflow), 32'(eov));
        chk(tag, "underflow", 32'(underflow), 32'(eun));
        chk(tag, "busy_at_done", 32'(busy), 32'd0);
        if (tail) begin
            repeat (3) begin
                @(posedge clk); #1;
                chk(tag, "no_extra_done", 32'(done), 32'd0);
            end
            chk(tag, "result_held", result, eres);
        end
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0; start = 1'b0; sign_in = 1'b0; exp_in = '0; mag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", "busy", 32'(busy), 32'd0);
        chk("reset", "done", 32'(done), 32'd0);
        chk("reset", "result", result, 32'h0);
        chk("reset", "flags", {30'd0, overflow, underflow}, 32'd0);
        reset_n = 1'b1;

        run_op(1'b0, 8'd127, 28'h8000000, 1, 0, 1, "one_plus_one");
        chk("one_plus_one", "const", result, 32'h40000000);
        run_op(1'b0, 8'd127, 28'h0400000, 1, 0, 1, "cancel");
        chk("cancel", "const", result, 32'h3D800000);
        run_op(1'b0, 8'd127, 28'h4000004, 1, 0, 1, "tie_even");
        chk("tie_even", "const", result, 32'h3F800000);
        run_op(1'b0, 8'd127, 28'h400000C, 1, 0, 1, "tie_odd");
        chk("tie_odd", "const", result, 32'h3F800002);
        run_op(1'b0, 8'd127, 28'h7FFFFFC, 1, 0, 1, "round_carry");
        chk("round_carry", "const", result, 32'h40000000);
        run_op(1'b0, 8'd254, 28'h8000000, 1, 0, 1, "overflow");
        chk("overflow", "const", result, 32'h7F800000);
        run_op(1'b1, 8'd1, 28'h2000000, 1, 0, 1, "underflow");
        chk("underflow", "const", result, 32'h80000000);
        run_op(1'b0, 8'd100, 28'h0000000, 1, 0, 1, "zero");
        run_op(1'b1, 8'd130, 28'h0800000, 1, 1, 1, "start_ignored");
        run_op(1'b0, 8'd127, 28'h8000000, 1, 0, 0, "b2b_first");
        run_op(1'b1, 8'd140, 28'h5555554, 0, 0, 1, "b2b_second");

        // Reset while a left-shift sequence is in progress.
        @(negedge clk);
        sign_in = 1'b0; exp_in = 8'd127; mag_in = 28'h0400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_reset", "busy", 32'(busy), 32'd0);
        chk("mid_reset", "done", 32'(done), 32'd0);
        chk("mid_reset", "result", result, 32'h0);
        chk("mid_reset", "flags", {30'd0, overflow, underflow}, 32'd0);
        reset_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1;
        end
        chk("mid_reset", "no_done", 32'(seen), 32'd0);
        $display("op mid_reset: busy=%0d result=%h", busy, result);

        for (int i = 0; i < 40; i++) begin
            logic [27:0] rm;
            logic [7:0]  re;
            rm = 28'($urandom) >> $urandom_range(0, 27);
            if ($urandom_range(0, 3) == 0) rm[27] = 1'b1;
            re = 8'($urandom_range(0, 254));
            run_op(1'($urandom), re, rm, 1, 0, 0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
